// File: rtl/pa_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// pa_sweep_ctrl : stepped-FCW chirp sequencer for a pipelined phase accumulator
// Revision 1.0
// ============================================================================
module pa_sweep_ctrl #(
  parameter int W        = 16,
  parameter int DW       = 8,
  parameter int PIPE_LAT = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  cfg_start,
  input  logic [W-1:0]  cfg_stop,
  input  logic [W-1:0]  cfg_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [W-1:0]  cfg_init,
  input  logic          cfg_repeat,
  input  logic          pa_wen_out,
  output logic [W-1:0]  fcw,
  output logic [W-1:0]  init,
  output logic          pa_reset_n,
  output logic          wen,
  output logic          busy,
  output logic          done,
  output logic          pipe_err
);

  localparam int DCW = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [W-1:0]  start_q;
  logic [W-1:0]  stop_q;
  logic [W-1:0]  step_q;
  logic [W-1:0]  init_q;
  logic [DW-1:0] dwell_q;
  logic          repeat_q;

  logic [DW-1:0] dwell_cnt;
  logic [DCW-1:0] drain_cnt;
  logic [DCW-1:0] elapsed;
  logic          pa_rst_q;
  logic          wen_dly;

  logic          dwell_exp;
  logic          sweep_end;
  logic          drain_last;
  logic          clip;
  logic [W:0]    nxt_sum;

  assign dwell_exp  = (dwell_cnt == dwell_q);
  assign nxt_sum    = {1'b0, fcw} + {1'b0, step_q};
  assign sweep_end  = (fcw == stop_q) || (step_q == '0) || (start_q >= stop_q);
  // A carry out means the sum wrapped past the top of the FCW range.
  assign clip       = nxt_sum[W] || (nxt_sum[W-1:0] >= stop_q);
  assign drain_last = (drain_cnt == DCW'(PIPE_LAT - 1));

  always_comb begin
    state_nxt  = state;
    wen        = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    pa_reset_n = pa_rst_q;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        pa_reset_n = 1'b0;
        state_nxt  = abort ? DRAIN : RUN;
      end
      RUN: begin
        wen = 1'b1;
        if (abort || (dwell_exp && sweep_end)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_last) begin
          done      = 1'b1;
          state_nxt = repeat_q ? LOAD : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      init_q    <= '0;
      dwell_q   <= '0;
      repeat_q  <= 1'b0;
      dwell_cnt <= '0;
      drain_cnt <= '0;
      fcw       <= '0;
      init      <= '0;
      pa_rst_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pa_rst_q <= 1'b1;

      if (state == IDLE && start) begin
        start_q  <= cfg_start;
        stop_q   <= cfg_stop;
        step_q   <= cfg_step;
        init_q   <= cfg_init;
        dwell_q  <= (cfg_dwell == '0) ? DW'(1) : cfg_dwell;
        repeat_q <= cfg_repeat;
      end

      if ((state == LOAD || state == RUN) && abort) repeat_q <= 1'b0;

      if (state == LOAD) begin
        fcw       <= start_q;
        init      <= init_q;
        dwell_cnt <= DW'(1);
      end

      if (state == RUN && !abort) begin
        if (!dwell_exp) begin
          dwell_cnt <= dwell_cnt + 1'b1;
        end else if (!sweep_end) begin
          fcw       <= clip ? stop_q : nxt_sum[W-1:0];
          dwell_cnt <= DW'(1);
        end
      end

      if (state == DRAIN && !drain_last) drain_cnt <= drain_cnt + 1'b1;
      else                               drain_cnt <= '0;
    end
  end

  // Delay line of wen, mirroring the accumulator's internal wen pipeline.
  generate
    if (PIPE_LAT > 1) begin : g_sr_multi
      logic [PIPE_LAT-1:0] wen_sr;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) wen_sr <= '0;
        else        wen_sr <= {wen_sr[PIPE_LAT-2:0], wen};
      end
      assign wen_dly = wen_sr[PIPE_LAT-1];
    end else begin : g_sr_single
      logic wen_sr;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) wen_sr <= 1'b0;
        else        wen_sr <= wen;
      end
      assign wen_dly = wen_sr;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elapsed  <= '0;
      pipe_err <= 1'b0;
    end else if (elapsed != DCW'(PIPE_LAT)) begin
      elapsed <= elapsed + 1'b1;
    end else if (pa_wen_out != wen_dly) begin
      pipe_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pa_sweep_ctrl.sv
`default_nettype none
// tb_pa_sweep_ctrl : directed and randomized sweeps checked against a behavioural
// list-of-FCW-values model; the accumulator is modelled as a 5-cycle wen delay.
module tb_pa_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cfg_start = '0;
  logic [15:0] cfg_stop = '0;
  logic [15:0] cfg_step = '0;
  logic [7:0]  cfg_dwell = '0;
  logic [15:0] cfg_init = '0;
  logic        cfg_repeat = 1'b0;
  logic        pa_wen_out;
  logic [15:0] fcw;
  logic [15:0] init;
  logic        pa_reset_n;
  logic        wen;
  logic        busy;
  logic        done;
  logic        pipe_err;

  logic [4:0]  acc_dly;
  logic        tie_low = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          model_vals[$];

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset)
    if (!reset) acc_dly <= '0;
    else        acc_dly <= {acc_dly[3:0], wen};
  assign pa_wen_out = tie_low ? 1'b0 : acc_dly[4];

  pa_sweep_ctrl #(.W(16), .DW(8), .PIPE_LAT(5)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_init(cfg_init), .cfg_repeat(cfg_repeat),
    .pa_wen_out(pa_wen_out), .fcw(fcw), .init(init), .pa_reset_n(pa_reset_n),
    .wen(wen), .busy(busy), .done(done), .pipe_err(pipe_err)
  );

  // Sequence of FCW values a sweep visits: start, then min(prev+step, stop).
  function automatic void model_build(input int s, input int e, input int st);
    int v;
    model_vals.delete();
    v = s;
    while (1) begin
      model_vals.push_back(v);
      if (v == e || st == 0 || s >= e) break;
      v = (v + st > e) ? e : v + st;
    end
  endfunction

  task automatic run_sweep(input string name, input int s, input int e, input int st,
                           input int dw, input int ini, input int abort_at,
                           input bit abort_with_start, input bit second_start);
    int d, nrun, ab;
    logic [15:0] exp_fcw, last;
    logic ew, er, eb, ed;
    d = (dw == 0) ? 1 : dw;
    model_build(s, e, st);
    nrun = model_vals.size() * d;
    ab = 0;
    if (abort_at > 0 && abort_at < nrun) begin
      nrun = abort_at;
      ab = abort_at;
    end
    last = 16'(model_vals[(nrun - 1) / d]);
    @(posedge clk); #1;
    cfg_start = 16'(s); cfg_stop = 16'(e); cfg_step = 16'(st);
    cfg_dwell = 8'(dw); cfg_init = 16'(ini); cfg_repeat = 1'b0;
    start = 1'b1; abort = abort_with_start;
    for (int c = 1; c <= nrun + 7; c++) begin
      @(posedge clk); #1;
      start = second_start && (c == nrun + 3);
      abort = (ab > 0) && (c == ab + 1);
      if (c == 1) begin
        cfg_start = 16'($urandom); cfg_stop = 16'($urandom); cfg_step = 16'($urandom);
        cfg_dwell = 8'($urandom); cfg_init = 16'($urandom); cfg_repeat = 1'b1;
      end
      ew = 1'b0; er = 1'b1; eb = 1'b1; ed = 1'b0; exp_fcw = last;
      if (c == 1) er = 1'b0;
      else if (c <= nrun + 1) begin
        ew = 1'b1;
        exp_fcw = 16'(model_vals[(c - 2) / d]);
      end
      else if (c == nrun + 6) ed = 1'b1;
      else if (c == nrun + 7) eb = 1'b0;
      checks++;
      if (wen !== ew) begin errors++; $display("FAIL %s wen cyc %0d: got %b want %b", name, c, wen, ew); end
      checks++;
      if (pa_reset_n !== er) begin errors++; $display("FAIL %s pa_reset_n cyc %0d: got %b want %b", name, c, pa_reset_n, er); end
      checks++;
      if (busy !== eb) begin errors++; $display("FAIL %s busy cyc %0d: got %b want %b", name, c, busy, eb); end
      checks++;
      if (done !== ed) begin errors++; $display("FAIL %s done cyc %0d: got %b want %b", name, c, done, ed); end
      checks++;
      if (pipe_err !== 1'b0) begin errors++; $display("FAIL %s pipe_err cyc %0d: got %b want 0", name, c, pipe_err); end
      if (c > 1) begin
        checks++;
        if (fcw !== exp_fcw) begin errors++; $display("FAIL %s fcw cyc %0d: got %h want %h", name, c, fcw, exp_fcw); end
        checks++;
        if (init !== 16'(ini)) begin errors++; $display("FAIL %s init cyc %0d: got %h want %h", name, c, init, 16'(ini)); end
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({fcw, init, pa_reset_n, wen, busy, done, pipe_err} !== 37'd0) begin
      errors++; $display("FAIL reset_values: got fcw=%h init=%h rn=%b wen=%b busy=%b done=%b perr=%b want all 0",
                         fcw, init, pa_reset_n, wen, busy, done, pipe_err);
    end
    @(negedge clk); reset = 1'b1; #1;
    checks++;
    if (pa_reset_n !== 1'b0) begin errors++; $display("FAIL reset_release_rn: got %b want 0", pa_reset_n); end
    @(posedge clk); #1;
    checks++;
    if (pa_reset_n !== 1'b1) begin errors++; $display("FAIL reset_first_edge_rn: got %b want 1", pa_reset_n); end
    abort = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || wen !== 1'b0 || fcw !== 16'h0) begin
        errors++; $display("FAIL idle_abort: got busy=%b wen=%b fcw=%h want 0 0 0000", busy, wen, fcw);
      end
    end
    abort = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic test_basic();
    run_sweep("basic", 'h1000, 'h1300, 'h0100, 3, 'h1234, 0, 1'b0, 1'b0);
  endtask

  task automatic test_carry_clip();
    run_sweep("carry_clip", 'hFF00, 'hFFFF, 'h0080, 1, 'h0042, 0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    run_sweep("abort", 'h1000, 'h1300, 'h0100, 3, 'h0001, 5, 1'b0, 1'b0);
  endtask

  task automatic test_degenerate();
    run_sweep("start_ge_stop", 'h2000, 'h1000, 'h0100, 0, 'h0bad, 0, 1'b0, 1'b1);
    run_sweep("step_zero", 'h2000, 'h3000, 'h0000, 0, 'h0cab, 0, 1'b0, 1'b1);
  endtask

  task automatic test_start_abort_idle();
    run_sweep("start_abort_idle", 'h0100, 'h0400, 'h0100, 2, 'h7777, 0, 1'b1, 1'b0);
  endtask

  task automatic test_repeat();
    int p, ph, cc, nrun;
    logic [15:0] exp_fcw;
    logic ew, er, eb, ed;
    model_build('h1000, 'h1300, 'h0100);
    nrun = model_vals.size();
    p = nrun + 6;
    @(posedge clk); #1;
    cfg_start = 16'h1000; cfg_stop = 16'h1300; cfg_step = 16'h0100;
    cfg_dwell = 8'd1; cfg_init = 16'h5555; cfg_repeat = 1'b1; start = 1'b1;
    for (int c = 1; c <= 2 * p + 8; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 1) cfg_repeat = 1'b0;
      abort = (c == 2 * p + 2);
      ew = 1'b0; er = 1'b1; eb = 1'b1; ed = 1'b0;
      exp_fcw = 16'(model_vals[nrun - 1]);
      if (c <= 2 * p) begin
        ph = (c - 1) % p;
        if (ph == 0) begin
          er = 1'b0;
          if (c == 1) exp_fcw = fcw;
        end
        else if (ph <= nrun) begin ew = 1'b1; exp_fcw = 16'(model_vals[ph - 1]); end
        else if (ph == p - 1) ed = 1'b1;
      end else begin
        cc = c - 2 * p;
        exp_fcw = 16'(model_vals[0]);
        if (cc == 1) begin er = 1'b0; exp_fcw = 16'(model_vals[nrun - 1]); end
        else if (cc == 2) ew = 1'b1;
        else if (cc == 7) ed = 1'b1;
        else if (cc == 8) eb = 1'b0;
      end
      checks++;
      if (wen !== ew) begin errors++; $display("FAIL repeat wen cyc %0d: got %b want %b", c, wen, ew); end
      checks++;
      if (pa_reset_n !== er) begin errors++; $display("FAIL repeat pa_reset_n cyc %0d: got %b want %b", c, pa_reset_n, er); end
      checks++;
      if (busy !== eb) begin errors++; $display("FAIL repeat busy cyc %0d: got %b want %b", c, busy, eb); end
      checks++;
      if (done !== ed) begin errors++; $display("FAIL repeat done cyc %0d: got %b want %b", c, done, ed); end
      checks++;
      if (fcw !== exp_fcw) begin errors++; $display("FAIL repeat fcw cyc %0d: got %h want %h", c, fcw, exp_fcw); end
    end
    abort = 1'b0;
  endtask

  task automatic test_random();
    int s, e, st, dw, span, lo, hi, ab;
    for (int i = 0; i < 25; i++) begin
      s = int'($urandom_range(0, 65535));
      span = int'($urandom_range(0, 1024));
      if ($urandom_range(0, 7) == 0) e = int'($urandom_range(0, 65535));
      else e = (s + span > 65535) ? 65535 : s + span;
      span = (e > s) ? e - s : 0;
      lo = span / 8 + 1;
      hi = ($urandom_range(0, 1) == 0) ? span / 2 + 1 : 65535;
      if (hi < lo) hi = lo;
      st = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(lo, hi));
      dw = int'($urandom_range(0, 4));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
      run_sweep("random", s, e, st, dw, int'($urandom_range(0, 65535)), ab, 1'b0,
                $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic test_pipe_err();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1; tie_low = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    cfg_start = 16'h1000; cfg_stop = 16'h1300; cfg_step = 16'h0100;
    cfg_dwell = 8'd3; cfg_init = 16'h0000; cfg_repeat = 1'b0; start = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (pipe_err !== (c >= 8)) begin
        errors++; $display("FAIL pipe_err_sticky cyc %0d: got %b want %b", c, pipe_err, c >= 8);
      end
    end
    tie_low = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_clip();
    test_abort();
    test_degenerate();
    test_start_abort_idle();
    test_repeat();
    test_random();
    test_pipe_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
